// File: rtl/sar_search.sv
// Successive-approximation search against an external three-way comparator.
// Optional early termination on an exact match: define SAR_EARLY_EXIT_EN.
module sar_search #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_l,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] KTOP = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  trial_q, trial_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [KW-1:0]     k_q, k_d;
    logic              found_q, found_d;
    logic              err_q, err_d;

    logic [WIDTH-1:0]  bit_k;
    logic [WIDTH-1:0]  resolved;
    logic              keep;
    logic              onehot;
    logic              last;

    assign bit_k    = LSB << k_q;
    // E outranks G outranks L; a code with nothing asserted falls to L.
    assign keep     = cmp_e | cmp_g;
    assign onehot   = {cmp_g, cmp_e, cmp_l} inside {3'b100, 3'b010, 3'b001};
    assign resolved = keep ? trial_q : (trial_q & ~bit_k);

`ifdef SAR_EARLY_EXIT_EN
    assign last = cmp_e || (k_q == '0);
`else
    assign last = (k_q == '0);
`endif

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        k_d      = k_q;
        found_d  = found_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COMPARE;
                    trial_d = MSB;
                    k_d     = KTOP;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                found_d = found_q | cmp_e;
                err_d   = err_q | ~onehot;
                trial_d = resolved;
                if (last) begin
                    state_d  = DONE;
                    result_d = resolved;
                end else begin
                    trial_d = resolved | (bit_k >> 1);
                    k_d     = k_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= KTOP;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            k_q      <= k_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign busy   = (state_q == COMPARE);
    assign done   = (state_q == DONE);
    assign found  = found_q;
    assign err    = err_q;

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of trial code and result (legal range 2..16).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new search; sampled in IDLE or DONE only.
REQ-005 cmp_g  input  1  external comparator: target > trial.
REQ-006 cmp_e  input  1  external comparator: target == trial.
REQ-007 cmp_l  input  1  external comparator: target < trial.
REQ-008 trial  output  WIDTH  registered code driven to the external comparator's B operand.
REQ-009 busy  output  1  high while in COMPARE.
REQ-010 done  output  1  one-cycle pulse when result is valid.
REQ-011 result  output  WIDTH  final code; held until the next accepted start.
REQ-012 found  output  1  an exact-equal compare occurred during the last search.
REQ-013 err  output  1  an illegal comparator code occurred during the last search.

Function
REQ-014 FSM states SHALL be IDLE, COMPARE and DONE.
REQ-015 start high in IDLE or DONE SHALL move to COMPARE at the next edge, load trial = 1<<(WIDTH-1), set bit index k = WIDTH-1, and clear found and err.
REQ-016 start while in COMPARE SHALL be ignored.
REQ-017 In COMPARE, each cycle SHALL sample cmp_g/cmp_e/cmp_l combinationally against the registered trial and resolve bit k at that edge: G or E keeps bit k; L clears bit k.
REQ-018 Comparator priority SHALL be E > G > L; none asserted SHALL be treated as L; any zero-hot or multi-hot code SHALL set err (sticky until the next start).
REQ-019 cmp_e high SHALL set found (sticky until the next start).
REQ-020 After resolving bit k with k > 0, trial SHALL set bit k-1 and decrement k.
REQ-021 After resolving bit 0, the FSM SHALL enter DONE; result SHALL load the resolved trial.
REQ-022 DONE SHALL last exactly one cycle with done = 1, then return to IDLE unless start is high.
REQ-023 Latency from the start-accept edge to the done pulse SHALL be WIDTH+1 cycles, early exit excluded.
REQ-024 For an ideal comparator, result SHALL equal the target for every target in 0..2^WIDTH-1.
REQ-025 Target 0 SHALL give result 0 and found 0; target 2^WIDTH-1 SHALL give an all-ones result.
REQ-026 trial SHALL hold its last value in IDLE and DONE.

Reset
REQ-027 rst_n low SHALL, asynchronously and at any time including mid-search, force state IDLE, trial = 0, result = 0, k = WIDTH-1, and busy = done = found = err = 0.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SAR_EARLY_EXIT_EN SHALL select early termination.
REQ-030 With SAR_EARLY_EXIT_EN defined, cmp_e in COMPARE SHALL end the search at that edge: result = current trial with lower bits zero, found = 1, next state DONE. Latency SHALL be (WIDTH-k)+1 cycles.
REQ-031 Without SAR_EARLY_EXIT_EN, all WIDTH bits SHALL always be resolved. cmp_e SHALL only set found and keep the bit.

Verification (WIDTH=8, bench models an ideal comparator against a target)
REQ-032 Target 0xA5, start pulse -> trial sequence 80,C0,A0,B0,A8,A4,A6,A5; done 9 cycles after accept; result 0xA5; found 1; err 0.
REQ-033 Target 0x00 and target 0xFF -> result 0x00 with found 0, and result 0xFF with found 1; err 0 in both.
REQ-034 Target 0x80 with SAR_EARLY_EXIT_EN -> done 2 cycles after accept, result 0x80, found 1. Same target without the macro -> done 9 cycles after accept, result 0x80.
REQ-035 Force cmp_g = cmp_l = 1 on the third compare of target 0x3C -> err 1 and the bit resolved as G. A new start clears err.
REQ-036 rst_n low at the 4th compare cycle -> all outputs 0 immediately. A start after release completes a search for 0x5A with result 0x5A.
REQ-037 start held high through a search and into DONE -> mid-search start ignored. Back-to-back search begins in the cycle after DONE with trial 0x80, and no IDLE cycle occurs.
